// File: rtl/hsem_ine_mc.sv
// hsem_ine_mc: per-core HSEM error capture, pending-interrupt and mask
// registers with per-core interrupt lines.
// Optional build macro HSEM_INE_HOLDOFF_EN adds a per-core re-assert holdoff
// FSM. The default build (macro undefined) drives intr straight from
// |(pend & mask).
module hsem_ine_mc #(
  parameter int                NUM_CORES   = 2,
  parameter int                DATA_W      = 32,
  parameter int                SEMERR_W    = 8,
  parameter logic [DATA_W-1:0] MASK_RST    = 32'hFFFF_FFFF,
  parameter int                HOLDOFF_CYC = 16
) (
  input  logic                          hclk,
  input  logic                          hresetn,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             ihwdata,
  input  logic [NUM_CORES-1:0]          int_sel,
  input  logic [NUM_CORES-1:0]          int_clr_sel,
  input  logic [NUM_CORES-1:0]          mask_sel,
  input  logic [NUM_CORES-1:0]          err_sel,
  input  logic [NUM_CORES-1:0]          err_clr_sel,
  input  logic [NUM_CORES*SEMERR_W-1:0] semerr,
  output logic [NUM_CORES-1:0]          intr,
  output logic [DATA_W-1:0]             rd_data
);

  // Saturating 8-bit increment used by the error counter.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = 8'hFF;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  logic [SEMERR_W-1:0] semerr_s    [NUM_CORES];
  logic [NUM_CORES-1:0] err_hit_s;

  logic [SEMERR_W-1:0] code_r      [NUM_CORES];
  logic [SEMERR_W-1:0] code_nxt_s  [NUM_CORES];
  logic [7:0]          cnt_r       [NUM_CORES];
  logic [7:0]          cnt_nxt_s   [NUM_CORES];
  logic [NUM_CORES-1:0] ovf_r;
  logic [NUM_CORES-1:0] ovf_nxt_s;

  logic [DATA_W-1:0]   pend_r      [NUM_CORES];
  logic [DATA_W-1:0]   pend_nxt_s  [NUM_CORES];
  logic [DATA_W-1:0]   mask_r      [NUM_CORES];
  logic [DATA_W-1:0]   mask_nxt_s  [NUM_CORES];
  logic [DATA_W-1:0]   err_s       [NUM_CORES];

  logic [NUM_CORES-1:0] intr_raw_s;
  logic [DATA_W-1:0]    rd_s;

  // Slice the packed error-code bus per core and flag a nonzero code.
  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      semerr_s[c]  = semerr[c*SEMERR_W +: SEMERR_W];
      err_hit_s[c] = |semerr_s[c];
    end
  end

  // Error register next state: a clear never drops a same-cycle error,
  // the first code is kept, later errors only count and set overflow.
  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      code_nxt_s[c] = code_r[c];
      cnt_nxt_s[c]  = cnt_r[c];
      ovf_nxt_s[c]  = ovf_r[c];
      if (err_clr_sel[c] && err_hit_s[c]) begin
        code_nxt_s[c] = semerr_s[c];
        cnt_nxt_s[c]  = 8'd1;
        ovf_nxt_s[c]  = 1'b0;
      end else if (err_clr_sel[c]) begin
        code_nxt_s[c] = {SEMERR_W{1'b0}};
        cnt_nxt_s[c]  = 8'd0;
        ovf_nxt_s[c]  = 1'b0;
      end else if (err_hit_s[c] && (code_r[c] == {SEMERR_W{1'b0}})) begin
        code_nxt_s[c] = semerr_s[c];
        cnt_nxt_s[c]  = sat_inc(cnt_r[c]);
      end else if (err_hit_s[c]) begin
        ovf_nxt_s[c]  = 1'b1;
        cnt_nxt_s[c]  = sat_inc(cnt_r[c]);
      end else begin
        code_nxt_s[c] = code_r[c];
      end
    end
  end

  // Pending and mask next state: write beats W1C, hardware set of bit 0
  // is applied last so it wins over any same-cycle software update.
  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      pend_nxt_s[c] = pend_r[c];
      mask_nxt_s[c] = mask_r[c];
      if (int_sel[c] && wr_en) begin
        pend_nxt_s[c] = ihwdata;
      end else if (int_clr_sel[c] && wr_en) begin
        pend_nxt_s[c] = pend_r[c] & ~ihwdata;
      end else begin
        pend_nxt_s[c] = pend_r[c];
      end
      pend_nxt_s[c][0] = pend_nxt_s[c][0] | err_hit_s[c];
      if (mask_sel[c] && wr_en) begin
        mask_nxt_s[c] = ihwdata;
      end else begin
        mask_nxt_s[c] = mask_r[c];
      end
    end
  end

  // Per-core register state.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        code_r[c] <= {SEMERR_W{1'b0}};
        cnt_r[c]  <= 8'd0;
        pend_r[c] <= {DATA_W{1'b0}};
        mask_r[c] <= MASK_RST;
      end
      ovf_r <= {NUM_CORES{1'b0}};
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        code_r[c] <= code_nxt_s[c];
        cnt_r[c]  <= cnt_nxt_s[c];
        pend_r[c] <= pend_nxt_s[c];
        mask_r[c] <= mask_nxt_s[c];
      end
      ovf_r <= ovf_nxt_s;
    end
  end

  // Assemble the readable error word and the raw interrupt condition.
  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      err_s[c]                 = {DATA_W{1'b0}};
      err_s[c][SEMERR_W-1:0]   = code_r[c];
      err_s[c][23:16]          = cnt_r[c];
      err_s[c][31]             = ovf_r[c];
      intr_raw_s[c]            = |(pend_r[c] & mask_r[c]);
    end
  end

  // Read mux: OR of every selected register; a multi-select only ORs.
  always_comb begin
    rd_s = {DATA_W{1'b0}};
    for (int c = 0; c < NUM_CORES; c++) begin
      rd_s = rd_s
           | (pend_r[c] & {DATA_W{int_sel[c] | int_clr_sel[c]}})
           | (mask_r[c] & {DATA_W{mask_sel[c]}})
           | (err_s[c]  & {DATA_W{err_sel[c]}});
    end
  end

  assign rd_data = rd_s;

`ifdef HSEM_INE_HOLDOFF_EN
  typedef enum logic {HO_IDLE = 1'b0, HO_HOLD = 1'b1} ho_state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF_CYC - 1);

  ho_state_t            ho_state_r     [NUM_CORES];
  ho_state_t            ho_state_nxt_s [NUM_CORES];
  logic [7:0]           ho_cnt_r       [NUM_CORES];
  logic [7:0]           ho_cnt_nxt_s   [NUM_CORES];
  logic [NUM_CORES-1:0] intr_raw_nxt_s;
  logic [NUM_CORES-1:0] intr_s;

  // Look one edge ahead so HOLD starts in the same cycle the raw line falls.
  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      intr_raw_nxt_s[c] = |(pend_nxt_s[c] & mask_nxt_s[c]);
    end
  end

  // Holdoff FSM state and counter registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        ho_state_r[c] <= HO_IDLE;
        ho_cnt_r[c]   <= 8'd0;
      end
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        ho_state_r[c] <= ho_state_nxt_s[c];
        ho_cnt_r[c]   <= ho_cnt_nxt_s[c];
      end
    end
  end

  // Holdoff next state and gated interrupt: a falling line suppresses
  // re-assertion for HOLDOFF_CYC cycles while pending bits accumulate.
  always_comb begin
    for (int c = 0; c < NUM_CORES; c++) begin
      ho_state_nxt_s[c] = ho_state_r[c];
      ho_cnt_nxt_s[c]   = ho_cnt_r[c];
      intr_s[c]         = 1'b0;
      case (ho_state_r[c])
        HO_IDLE: begin
          intr_s[c] = intr_raw_s[c];
          if (intr_raw_s[c] && !intr_raw_nxt_s[c]) begin
            ho_state_nxt_s[c] = HO_HOLD;
            ho_cnt_nxt_s[c]   = HOLD_LOAD;
          end else begin
            ho_state_nxt_s[c] = HO_IDLE;
            ho_cnt_nxt_s[c]   = 8'd0;
          end
        end
        HO_HOLD: begin
          intr_s[c] = 1'b0;
          if (ho_cnt_r[c] == 8'd0) begin
            ho_state_nxt_s[c] = HO_IDLE;
          end else begin
            ho_cnt_nxt_s[c]   = ho_cnt_r[c] - 8'd1;
          end
        end
        default: begin
          ho_state_nxt_s[c] = HO_IDLE;
          ho_cnt_nxt_s[c]   = 8'd0;
        end
      endcase
    end
  end

  assign intr = intr_s;
`else
  assign intr = intr_raw_s;
`endif

endmodule

// File: tb/tb_hsem_ine_mc.sv
// Self-checking bench for hsem_ine_mc (NUM_CORES=4): directed scenarios plus
// randomized traffic compared every cycle against a field-level model.
module tb_hsem_ine_mc;
  localparam int NC = 4;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        wr_en;
  logic [31:0] ihwdata;
  logic [3:0]  int_sel, int_clr_sel, mask_sel, err_sel, err_clr_sel;
  logic [31:0] semerr;
  logic [3:0]  intr;
  logic [31:0] rd_data;

  int n_chk = 0;
  int n_err = 0;

  // reference model state, one entry per core
  int unsigned m_code [NC];
  int unsigned m_cnt  [NC];
  bit          m_ovf  [NC];
  logic [31:0] m_pend [NC];
  logic [31:0] m_mask [NC];
  int          hold_left [NC];

  hsem_ine_mc #(.NUM_CORES(NC)) dut (
    .hclk(hclk), .hresetn(hresetn), .wr_en(wr_en), .ihwdata(ihwdata),
    .int_sel(int_sel), .int_clr_sel(int_clr_sel), .mask_sel(mask_sel),
    .err_sel(err_sel), .err_clr_sel(err_clr_sel), .semerr(semerr),
    .intr(intr), .rd_data(rd_data)
  );

  always #5 hclk = ~hclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_err(input int c);
    return (32'(m_ovf[c]) << 31) | (32'(m_cnt[c]) << 16) | 32'(m_code[c]);
  endfunction

  function automatic logic [3:0] m_intr();
    logic [3:0] v;
    for (int c = 0; c < NC; c++) begin
      v[c] = ((m_pend[c] & m_mask[c]) != 32'd0) && (hold_left[c] == 0);
    end
    return v;
  endfunction

  function automatic logic [31:0] m_rd();
    logic [31:0] v = 32'd0;
    for (int c = 0; c < NC; c++) begin
      if (int_sel[c] || int_clr_sel[c]) v |= m_pend[c];
      if (mask_sel[c]) v |= m_mask[c];
      if (err_sel[c])  v |= m_err(c);
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_code[c] = 0; m_cnt[c] = 0; m_ovf[c] = 1'b0;
      m_pend[c] = 32'd0; m_mask[c] = 32'hFFFF_FFFF; hold_left[c] = 0;
    end
  endtask

  // apply one clock edge worth of register updates from the current inputs
  task automatic model_update();
    for (int c = 0; c < NC; c++) begin
      int unsigned e = (semerr >> (8 * c)) & 32'hFF;
      bit old_raw = (m_pend[c] & m_mask[c]) != 32'd0;
      bit new_raw;
      if (err_clr_sel[c] && e != 0) begin
        m_code[c] = e; m_cnt[c] = 1; m_ovf[c] = 1'b0;
      end else if (err_clr_sel[c]) begin
        m_code[c] = 0; m_cnt[c] = 0; m_ovf[c] = 1'b0;
      end else if (e != 0) begin
        if (m_code[c] == 0) m_code[c] = e;
        else m_ovf[c] = 1'b1;
        m_cnt[c] = (m_cnt[c] >= 255) ? 255 : m_cnt[c] + 1;
      end
      if (wr_en && int_sel[c]) m_pend[c] = ihwdata;
      else if (wr_en && int_clr_sel[c]) m_pend[c] = m_pend[c] & ~ihwdata;
      if (e != 0) m_pend[c] = m_pend[c] | 32'd1;
      if (wr_en && mask_sel[c]) m_mask[c] = ihwdata;
      new_raw = (m_pend[c] & m_mask[c]) != 32'd0;
`ifdef HSEM_INE_HOLDOFF_EN
      if (hold_left[c] > 0) hold_left[c]--;
      else if (old_raw && !new_raw) hold_left[c] = 16;
`else
      if (old_raw && !new_raw) hold_left[c] = 0;
`endif
    end
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; ihwdata = 32'd0; semerr = 32'd0;
    int_sel = 4'd0; int_clr_sel = 4'd0; mask_sel = 4'd0;
    err_sel = 4'd0; err_clr_sel = 4'd0;
  endtask

  // check outputs against the model, then clock once and update the model
  task automatic tick(input string tag);
    #1;
    check_eq({tag, ":intr"}, {28'd0, intr}, {28'd0, m_intr()});
    check_eq({tag, ":rd"}, rd_data, m_rd());
    @(posedge hclk);
    model_update();
    @(negedge hclk);
  endtask

  function automatic logic [3:0] rand_sel();
    int r = $urandom_range(0, 9);
    logic [3:0] v;
    if (r < 5) v = 4'd0;
    else if (r < 9) v = 4'd1 << $urandom_range(0, 3);
    else v = 4'($urandom);
    return v;
  endfunction

  initial begin
    hresetn = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge hclk);
    #1;
    check_eq("rst_intr", {28'd0, intr}, 32'd0);
    check_eq("rst_rd", rd_data, 32'd0);
    hresetn = 1'b1;
    @(negedge hclk);

    // reset values readable through the mux
    mask_sel = 4'b0001; #1;
    check_eq("rst_mask0", rd_data, 32'hFFFF_FFFF);
    mask_sel = 4'b0000; err_sel = 4'b0100; #1;
    check_eq("rst_err2", rd_data, 32'd0);
    idle_inputs();

    // first error capture, then overflow on a second code
    semerr = 32'h0005_0000; tick("err2a");
    idle_inputs(); err_sel = 4'b0100; #1;
    check_eq("err2_first", rd_data, 32'h0001_0005);
    check_eq("intr_after_err", {28'd0, intr}, 32'h0000_0004);
    err_sel = 4'b0000; int_sel = 4'b0100; #1;
    check_eq("pend2", rd_data, 32'h0000_0001);
    idle_inputs(); semerr = 32'h0009_0000; tick("err2b");
    idle_inputs(); err_sel = 4'b0100; #1;
    check_eq("err2_ovf", rd_data, 32'h8002_0005);
    idle_inputs();

    // software pending write then W1C
    int_sel = 4'b0010; wr_en = 1'b1; ihwdata = 32'h30; tick("pw1");
    idle_inputs(); int_clr_sel = 4'b0010; wr_en = 1'b1; ihwdata = 32'h10; tick("w1c1");
    idle_inputs(); int_sel = 4'b0010; #1;
    check_eq("pend1_20", rd_data, 32'h20);
    check_eq("intr1_held", {31'd0, intr[1]}, 32'd1);
    idle_inputs(); int_clr_sel = 4'b0010; wr_en = 1'b1; ihwdata = 32'h20; tick("w1c2");
    idle_inputs(); #1;
    check_eq("intr1_low", {31'd0, intr[1]}, 32'd0);

    // clear with simultaneous error, W1C vs hardware set
    err_clr_sel = 4'b0001; semerr = 32'h0000_0003; tick("clr_err");
    idle_inputs(); err_sel = 4'b0001; #1;
    check_eq("err0_clrnew", rd_data, 32'h0001_0003);
    idle_inputs(); int_clr_sel = 4'b0001; wr_en = 1'b1; ihwdata = 32'h1;
    semerr = 32'h0000_0003; tick("w1c_hw");
    idle_inputs(); int_sel = 4'b0001; #1;
    check_eq("pend0_bit0", {31'd0, rd_data[0]}, 32'd1);
    idle_inputs();

    // masking and counter saturation on core 3
    mask_sel = 4'b1000; wr_en = 1'b1; ihwdata = 32'h0; tick("mask3_0");
    idle_inputs(); semerr = 32'h0100_0000; tick("err3");
    idle_inputs(); int_sel = 4'b1000; #1;
    check_eq("pend3", rd_data, 32'h1);
    check_eq("intr3_masked", {31'd0, intr[3]}, 32'd0);
    idle_inputs(); mask_sel = 4'b1000; wr_en = 1'b1; ihwdata = 32'h1; tick("mask3_1");
    idle_inputs(); #1;
    check_eq("intr3_unmasked", {31'd0, intr[3]}, 32'd1);
    semerr = 32'h1100_0000;
    for (int i = 0; i < 300; i++) tick("sat");
    idle_inputs(); err_sel = 4'b1000; #1;
    check_eq("cnt3_sat", rd_data, 32'h80FF_0001);
    idle_inputs();

    // randomized traffic, including occasional multi-selects
    for (int i = 0; i < 400; i++) begin
      wr_en = 1'($urandom);
      ihwdata = $urandom;
      if ($urandom_range(0, 3) == 0) ihwdata = ihwdata & 32'h0000_000F;
      int_sel = rand_sel(); int_clr_sel = rand_sel(); mask_sel = rand_sel();
      err_sel = rand_sel(); err_clr_sel = rand_sel();
      for (int c = 0; c < NC; c++) begin
        semerr[8*c +: 8] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      end
      tick("rnd");
    end
    idle_inputs();

`ifdef HSEM_INE_HOLDOFF_EN
    // holdoff: fall, re-raise two cycles later, line stays low 16 cycles
    hresetn = 1'b0; model_reset(); #1; hresetn = 1'b1;
    @(negedge hclk);
    int_sel = 4'b0001; wr_en = 1'b1; ihwdata = 32'h1; tick("ho_set");
    idle_inputs(); tick("ho_idle");
    int_clr_sel = 4'b0001; wr_en = 1'b1; ihwdata = 32'h1; tick("ho_fall");
    for (int i = 0; i < 20; i++) begin
      idle_inputs();
      if (i == 1) begin int_sel = 4'b0001; wr_en = 1'b1; ihwdata = 32'h1; end
      #1;
      check_eq("ho_window", {31'd0, intr[0]}, (i >= 16) ? 32'd1 : 32'd0);
      tick("ho_run");
    end
    // async reset in the middle of a hold window
    idle_inputs(); int_clr_sel = 4'b0001; wr_en = 1'b1; ihwdata = 32'h1; tick("ho_fall2");
    idle_inputs(); repeat (3) tick("ho_mid");
    hresetn = 1'b0; model_reset(); #1;
    check_eq("ho_rst_intr", {28'd0, intr}, 32'd0);
    hresetn = 1'b1;
    @(negedge hclk);
    int_sel = 4'b0001; wr_en = 1'b1; ihwdata = 32'h1; tick("ho_post");
    idle_inputs(); #1;
    check_eq("ho_post_idle", {31'd0, intr[0]}, 32'd1);
    tick("ho_end");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/hsem_ine_mc.md
Name: hsem_ine_mc

Overview:
- Next-generation HSEM interrupt and error controller, generalised from two fixed cores to NUM_CORES cores.
- Per core it holds:
  - an error register with first-error capture, a saturating error counter and an overflow flag;
  - a pending-interrupt register (hardware error bit plus software bits, write-1-to-clear);
  - an interrupt mask register.
- Sits between the HSEM AHB register decoder (one-hot per-core selects, write data) and the per-core interrupt lines at the top level.

Parameters:
- NUM_CORES, 2, number of cores/channels (1..16).
- DATA_W, 32, AHB data width; register width (fixed layout needs 32).
- SEMERR_W, 8, width of per-core error code from semaphore logic (<=16).
- MASK_RST, 32'hFFFF_FFFF, reset value of every mask register.
- HOLDOFF_CYC, 16, re-assert holdoff length in cycles (optional feature only; 1..255).

Ports:
- hclk  in  1  clock.
- hresetn  in  1  asynchronous active-low reset.
- wr_en  in  1  AHB write qualifier for the current data phase.
- ihwdata  in  DATA_W  AHB write data.
- int_sel  in  NUM_CORES  one-hot select of pending register (read/write set).
- int_clr_sel  in  NUM_CORES  one-hot select of pending W1C register.
- mask_sel  in  NUM_CORES  one-hot select of mask register.
- err_sel  in  NUM_CORES  one-hot select of error register (read).
- err_clr_sel  in  NUM_CORES  strobe: clear error register of core c.
- semerr  in  NUM_CORES*SEMERR_W  per-core error codes, core c at [c*SEMERR_W +: SEMERR_W]; nonzero means error this cycle.
- intr  out  NUM_CORES  per-core interrupt lines.
- rd_data  out  DATA_W  OR of all selected registers; 0 when nothing is selected.

Behaviour:
- Reset (hresetn low, async): err, pend and count are 0, mask is MASK_RST, intr is 0, rd_data is 0.
- Error register layout, err[c]:
  - [SEMERR_W-1:0] first error code.
  - [23:16] error count, saturates at 255.
  - [31] overflow.
  - All other bits read 0.
- Error register updates per cycle, priority high to low:
  - (a) err_clr_sel[c] with semerr_c != 0: code <= semerr_c, count <= 1, ovf <= 0. A new error is never lost to a clear.
  - (b) err_clr_sel[c] alone: all fields <= 0.
  - (c) semerr_c != 0 and code == 0: code <= semerr_c, count <= count+1.
  - (d) semerr_c != 0 and code != 0: code held, ovf <= 1, count <= sat(count+1).
  - (e) otherwise: hold.
- Pending register pend[c]; bit 0 is the HW error bit. Next value:
  - Start from the current value.
  - Write (int_sel[c] & wr_en): replace with ihwdata.
  - W1C (int_clr_sel[c] & wr_en): AND with ~ihwdata.
  - Hardware set: bit 0 is ORed with (semerr_c != 0) after the write/W1C, so hardware set wins over a same-cycle write or clear.
  - int_sel and int_clr_sel for the same core in the same cycle: write applies, W1C is ignored.
- Mask register: mask[c] <= ihwdata when mask_sel[c] & wr_en.
- intr[c] = |(pend[c] & mask[c]):
  - combinational from registers, no combinational path from inputs;
  - latency semerr -> intr is 1 cycle;
  - latency W1C/mask write -> intr change is 1 cycle.
- rd_data (combinational): OR over all cores of
  - (int_sel|int_clr_sel)[c] ? pend[c]
  - mask_sel[c] ? mask[c]
  - err_sel[c] ? err[c]
  - Multiple selects are a decoder fault; the output is the OR, with no other side effect.
- Cores are fully independent; simultaneous events on different cores are all applied in the same cycle.

Optional Feature:
- Macro HSEM_INE_HOLDOFF_EN.
- Defined: per core, a 2-state FSM IDLE/HOLD with an 8-bit counter.
  - When intr_raw[c] (= |(pend&mask)) falls 1 -> 0, go to HOLD and load HOLDOFF_CYC-1.
  - In HOLD: intr[c] is forced to 0 and the counter decrements each cycle; at 0, return to IDLE.
  - Pending bits keep accumulating during HOLD; intr re-asserts on the first IDLE cycle if intr_raw is still 1.
  - Reset puts the FSM in IDLE with the counter at 0.
- Undefined: intr = intr_raw, no FSM or counter logic instantiated.

Test Plan:
- Reset release, NUM_CORES=4 -> intr=0; read mask_sel=4'b0001 gives rd_data 32'hFFFF_FFFF; err_sel=4'b0100 gives 0.
- semerr core2=8'h05 for 1 cycle -> next cycle intr=4'b0100, err[2]=32'h0001_0005, pend[2]=1; then semerr core2=8'h09 -> err[2]=32'h8002_0005.
- Core1 write pend=32'h0000_0030, then W1C 32'h10 -> pend=32'h20, intr[1] stays 1; W1C 32'h20 -> intr[1]=0 the next cycle.
- Same cycle: err_clr_sel[0] with semerr core0=8'h03 -> err[0]=32'h0001_0003; W1C bit0 with semerr nonzero -> pend bit0 stays 1.
- Mask core3 = 0, trigger error -> pend[3]=1, intr[3]=0; write mask 1 -> intr[3]=1 the next cycle; 300 errors -> count saturates at 8'hFF.
- HSEM_INE_HOLDOFF_EN, HOLDOFF_CYC=16: clear core0 then re-raise the error 2 cycles later -> intr[0] low for exactly 16 cycles after the fall, then high; async reset mid-HOLD -> IDLE, intr=0.
